// File: rtl/eb1_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eb1_uart_pkg
// Description : Definitions shared by the EB1 UART transmitter and receiver.
//               Provides the 3-bit FSM state encoding, the frame bit counts,
//               the serial line levels and the bit-period helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eb1_uart_pkg;

    // PARITY keeps its encoding in every build so both ends of the link agree
    // on the state values even when parity is not compiled in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } uart_state_e;

    localparam int unsigned c_DATA_BITS       = 8;
    localparam int unsigned c_FRAME_BITS      = 10;  // start + 8 data + stop
    localparam int unsigned c_FRAME_BITS_PAR  = 11;  // with the parity bit
    localparam logic        c_LINE_IDLE       = 1'b1;
    localparam logic        c_START_LEVEL     = 1'b0;
    localparam logic        c_STOP_LEVEL      = 1'b1;

    // A programmed period of 0 would never end a bit, so it runs as 1 clock.
    function automatic logic [15:0] eff_period(input logic [15:0] clks);
        return (clks == 16'd0) ? 16'd1 : clks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eb1_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eb1_uart_tx_fifo
// Description : Synchronous byte FIFO feeding the UART transmitter.
//               Read data is first-word fall-through (o_data shows the head
//               entry whenever o_empty is low).
// Ports       : i_Clock  - clock
//               rst_i    - asynchronous active-high reset (empties the FIFO)
//               i_push   - write strobe, ignored while full
//               i_data   - byte to write
//               i_pop    - read strobe, ignored while empty
//               o_data   - head entry
//               o_full   - FIFO_DEPTH entries held
//               o_empty  - no entries held
//               o_count  - entries held
// Parameters  : FIFO_DEPTH - entries, power of two and at least 2
// Revision    : 1.0 - initial release
// ============================================================================
module eb1_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          rst_i,
    input  logic                          i_push,
    input  logic [7:0]                    i_data,
    input  logic                          i_pop,
    output logic [7:0]                    o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int              c_AW   = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Full/empty decode the registered count, so a push in the same cycle as
    // a pop from a full FIFO is still refused.
    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_Clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eb1_uart_tx_prog.sv
`default_nettype none
// ============================================================================
// Module      : eb1_uart_tx_prog
// Description : 8N1 UART transmitter with a run-time bit period and a small
//               transmit FIFO. Bytes go out LSB first; the bit period is
//               latched from CLKS_PER_BIT at every frame start.
// Ports       : i_Clock      - clock
//               rst_i        - asynchronous active-high reset
//               CLKS_PER_BIT - clocks per serial bit (0 behaves as 1)
//               i_Tx_DV      - push strobe, taken when o_Tx_Ready is high
//               i_Tx_Byte    - byte to push
//               o_Tx_Ready   - FIFO not full
//               o_Tx_Serial  - serial line, idle high
//               o_Tx_Active  - frame in progress (start through stop)
//               o_Tx_Done    - one-cycle pulse after each stop bit
//               o_Fifo_Count - bytes queued, excluding the frame in flight
// Parameters  : FIFO_DEPTH   - FIFO entries, power of two, at least 2
// Macros      : EB1_UART_TX_PARITY_EN - adds an even-parity bit between the
//               data bits and the stop bit (11-bit frames)
// Revision    : 1.0 - initial release
// ============================================================================
module eb1_uart_tx_prog
    import eb1_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          rst_i,
    input  logic [15:0]                   CLKS_PER_BIT,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    uart_state_e r_state,   w_state;
    logic [15:0] r_clk_cnt, w_clk_cnt;
    logic [15:0] r_period,  w_period;
    logic [7:0]  r_shift,   w_shift;
    logic [2:0]  r_bit_idx, w_bit_idx;
    logic        r_parity,  w_parity;
    logic        r_serial,  w_serial;
    logic        r_active,  w_active;
    logic        r_done,    w_done;

    logic        w_bit_end;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_data;

    eb1_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .rst_i   (rst_i),
        .i_push  (i_Tx_DV),
        .i_data  (i_Tx_Byte),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_Fifo_Count)
    );

    assign o_Tx_Ready  = ~w_fifo_full;
    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;

    // r_period is never 0, so the subtraction cannot wrap.
    assign w_bit_end = (r_clk_cnt == r_period - 16'd1);

    always_ff @(posedge i_Clock or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_period  <= 16'd1;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_serial  <= c_LINE_IDLE;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_clk_cnt <= w_clk_cnt;
            r_period  <= w_period;
            r_shift   <= w_shift;
            r_bit_idx <= w_bit_idx;
            r_parity  <= w_parity;
            r_serial  <= w_serial;
            r_active  <= w_active;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_clk_cnt = r_clk_cnt;
        w_period  = r_period;
        w_shift   = r_shift;
        w_bit_idx = r_bit_idx;
        w_parity  = r_parity;
        w_pop     = 1'b0;

        case (r_state)
            // CLEANUP shares IDLE's pop so queued bytes follow after exactly
            // one high cycle.
            ST_IDLE, ST_CLEANUP: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_state   = ST_START;
                    w_shift   = w_fifo_data;
                    w_parity  = ^w_fifo_data;
                    w_period  = eff_period(CLKS_PER_BIT);
                    w_clk_cnt = '0;
                    w_bit_idx = '0;
                end else begin
                    w_state   = ST_IDLE;
                end
            end
            ST_START: begin
                w_clk_cnt = r_clk_cnt + 16'd1;
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    w_state   = ST_DATA;
                end
            end
            ST_DATA: begin
                w_clk_cnt = r_clk_cnt + 16'd1;
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    if (r_bit_idx == 3'(c_DATA_BITS - 1)) begin
`ifdef EB1_UART_TX_PARITY_EN
                        w_state = ST_PARITY;
`else
                        w_state = ST_STOP;
`endif
                    end else begin
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                w_clk_cnt = r_clk_cnt + 16'd1;
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    w_state   = ST_STOP;
                end
            end
            ST_STOP: begin
                w_clk_cnt = r_clk_cnt + 16'd1;
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    w_state   = ST_CLEANUP;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered rather than the current one.
        case (w_state)
            ST_START:  w_serial = c_START_LEVEL;
            ST_DATA:   w_serial = w_shift[0];
            ST_PARITY: w_serial = w_parity;
            ST_STOP:   w_serial = c_STOP_LEVEL;
            default:   w_serial = c_LINE_IDLE;
        endcase
        w_active = (w_state == ST_START) || (w_state == ST_DATA) ||
                   (w_state == ST_PARITY) || (w_state == ST_STOP);
        w_done   = (r_state == ST_STOP) && w_bit_end;
    end

endmodule
`default_nettype wire

// File: tb/tb_eb1_uart_tx_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_eb1_uart_tx_prog
// Description : Self-checking bench for eb1_uart_tx_prog. A frame monitor
//               decodes the serial line against a queue of expected bytes;
//               directed steps check timing, FIFO limits and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eb1_uart_tx_prog;

`ifdef EB1_UART_TX_PARITY_EN
    localparam int c_NB = 11;
`else
    localparam int c_NB = 10;
`endif

    logic        i_Clock = 1'b0;
    logic        rst_i   = 1'b1;
    logic [15:0] CLKS_PER_BIT = 16'd4;
    logic        i_Tx_DV  = 1'b0;
    logic [7:0]  i_Tx_Byte = 8'h00;
    logic        o_Tx_Ready;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic [2:0]  o_Fifo_Count;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  sb[$];
    bit          mon_busy = 1'b0;
    int          n_frames = 0;
    int          start_cyc[64];

    int          m_p, m_bad, m_actbad;
    logic [7:0]  m_b;
    logic [10:0] m_ef, m_of;
    bit          m_ab;

    eb1_uart_tx_prog #(
        .FIFO_DEPTH (4)
    ) dut (
        .i_Clock      (i_Clock),
        .rst_i        (rst_i),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Fifo_Count (o_Fifo_Count)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame monitor: expected byte popped at each start bit, every cycle of
    // every bit compared against the model frame.
    initial begin : monitor
        forever begin
            @(negedge i_Clock);
            if (!rst_i && o_Tx_Serial === 1'b0) begin
                mon_busy = 1'b1;
                start_cyc[n_frames % 64] = cyc;
                m_p = (CLKS_PER_BIT == 16'd0) ? 1 : int'(CLKS_PER_BIT);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    m_b = 8'h00;
                end else begin
                    m_b = sb.pop_front();
                end
`ifdef EB1_UART_TX_PARITY_EN
                m_ef = {1'b1, ^m_b, m_b, 1'b0};
`else
                m_ef = {1'b0, 1'b1, m_b, 1'b0};
`endif
                m_of = '0; m_bad = 0; m_actbad = 0; m_ab = 1'b0;
                for (int i = 0; i < c_NB && !m_ab; i++) begin
                    for (int c = 0; c < m_p && !m_ab; c++) begin
                        if (i != 0 || c != 0) @(negedge i_Clock);
                        if (rst_i) begin
                            m_ab = 1'b1;
                        end else begin
                            if (c == 0) m_of[i] = o_Tx_Serial;
                            if (o_Tx_Serial !== m_ef[i]) m_bad++;
                            if (o_Tx_Active !== 1'b1 || o_Tx_Done !== 1'b0) m_actbad++;
                        end
                    end
                end
                if (!m_ab) begin
                    @(negedge i_Clock);
                    if (!rst_i) begin
                        chk("cleanup_done", o_Tx_Done, 1);
                        chk("cleanup_line", o_Tx_Serial, 1);
                        chk("cleanup_active", o_Tx_Active, 0);
                    end
                    chk("frame_bits", m_of, m_ef);
                    chk("bit_hold_errs", m_bad, 0);
                    chk("active_in_frame_errs", m_actbad, 0);
                    n_frames++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge i_Clock);
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = b;
        @(posedge i_Clock);
        #1;
        i_Tx_DV   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || mon_busy || o_Tx_Active !== 1'b0 ||
                o_Fifo_Count !== 3'd0) && n < 4000) begin
            @(posedge i_Clock); #1; n++;
        end
        chk("idle_timeout", (n < 4000), 1);
        repeat (3) @(posedge i_Clock);
        #1;
    endtask

    // Called just after the push edge k of a byte into an idle, empty FIFO.
    task automatic measure(input int exp_done, input int exp_act);
        int n;
        int act;
        chk("pre_start_line", o_Tx_Serial, 1);
        chk("pre_start_count", o_Fifo_Count, 1);
        @(posedge i_Clock); #1;
        chk("start_line", o_Tx_Serial, 0);
        chk("start_active", o_Tx_Active, 1);
        chk("start_count", o_Fifo_Count, 0);
        n = 1; act = 1;
        while (o_Tx_Done !== 1'b1 && n < 2000) begin
            @(posedge i_Clock); #1; n++;
            if (o_Tx_Active === 1'b1) act++;
        end
        chk("done_latency", n, exp_done);
        chk("active_cycles", act, exp_act);
    endtask

    initial begin : stim
        int f0;
        int quiet;

        // Reset state
        repeat (3) @(posedge i_Clock);
        #1;
        chk("rst_line", o_Tx_Serial, 1);
        chk("rst_active", o_Tx_Active, 0);
        chk("rst_done", o_Tx_Done, 0);
        chk("rst_ready", o_Tx_Ready, 1);
        chk("rst_count", o_Fifo_Count, 0);
        @(negedge i_Clock);
        rst_i = 1'b0;

        // Single frame, P=4, 0xA5
        CLKS_PER_BIT = 16'd4;
        sb.push_back(8'hA5);
        push_byte(8'hA5);
        measure(1 + c_NB * 4, c_NB * 4);
        wait_idle();

        // Four back-to-back bytes
        f0 = n_frames;
        foreach (sb[i]) sb.delete(i);
        sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'h3C); sb.push_back(8'h81);
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h3C); push_byte(8'h81);
        chk("burst4_count", o_Fifo_Count, 3);
        chk("burst4_ready", o_Tx_Ready, 1);
        wait_idle();
        chk("burst4_frames", n_frames - f0, 4);
        for (int i = 0; i < 3; i++)
            chk("burst4_gap", start_cyc[(f0 + i + 1) % 64] - start_cyc[(f0 + i) % 64], c_NB * 4 + 1);

        // Overfill: sixth push dropped
        CLKS_PER_BIT = 16'd16;
        f0 = n_frames;
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        sb.push_back(8'h44); sb.push_back(8'h55);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        push_byte(8'h44); push_byte(8'h55);
        chk("full_ready", o_Tx_Ready, 0);
        push_byte(8'hEE);
        chk("full_count", o_Fifo_Count, 4);
        chk("full_ready_after", o_Tx_Ready, 0);
        wait_idle();
        chk("full_frames", n_frames - f0, 5);

        // Bit period change mid-frame, then period 0
        CLKS_PER_BIT = 16'd8;
        f0 = n_frames;
        sb.push_back(8'h5A); sb.push_back(8'h81);
        push_byte(8'h5A);
        repeat (10) @(posedge i_Clock);
        push_byte(8'h81);
        repeat (15) @(posedge i_Clock);
        #1;
        CLKS_PER_BIT = 16'd3;
        wait_idle();
        chk("period_frames", n_frames - f0, 2);
        chk("period_gap", start_cyc[(f0 + 1) % 64] - start_cyc[f0 % 64], c_NB * 8 + 1);
        CLKS_PER_BIT = 16'd0;
        sb.push_back(8'hC3);
        push_byte(8'hC3);
        measure(1 + c_NB, c_NB);
        wait_idle();
        chk("period0_frames", n_frames - f0, 3);

        // Reset in the DATA state
        CLKS_PER_BIT = 16'd4;
        sb.push_back(8'h96); sb.push_back(8'h12); sb.push_back(8'h34);
        push_byte(8'h96); push_byte(8'h12); push_byte(8'h34);
        repeat (15) @(posedge i_Clock);
        #1;
        chk("pre_rst_line", o_Tx_Serial, 0);
        rst_i = 1'b1;
        #1;
        chk("midrst_line", o_Tx_Serial, 1);
        chk("midrst_count", o_Fifo_Count, 0);
        chk("midrst_ready", o_Tx_Ready, 1);
        chk("midrst_active", o_Tx_Active, 0);
        repeat (2) @(negedge i_Clock);
        rst_i = 1'b0;
        sb.delete();
        quiet = 0;
        repeat (20) begin
            @(posedge i_Clock); #1;
            if (o_Tx_Done !== 1'b0 || o_Tx_Serial !== 1'b1) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        f0 = n_frames;
        sb.push_back(8'h3C);
        push_byte(8'h3C);
        measure(1 + c_NB * 4, c_NB * 4);
        wait_idle();
        chk("post_rst_frames", n_frames - f0, 1);

`ifdef EB1_UART_TX_PARITY_EN
        CLKS_PER_BIT = 16'd2;
        sb.push_back(8'h07);
        push_byte(8'h07);
        measure(23, 22);
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
